// File: rtl/wmem_pkg.sv
// Shared types and helpers for the binary-weight memory (wmem_burst, wmem_array).
package wmem_pkg;

    typedef enum logic [1:0] {StInit, StIdle, StBurst, StDrain} wmem_state_e;

    // Alternating weight pattern, bit 0 set; valid for word widths up to 64.
    function automatic logic [63:0] init_pat(input int unsigned w);
        logic [63:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if ((i < w) && ((i % 2) == 0)) pat[i] = 1'b1;
        end
        return pat;
    endfunction

    // Even parity over a zero-extended word.
    function automatic logic parity64(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/wmem_array.sv
// Simple dual-port weight storage: one write port, one registered read port, no reset.
module wmem_array #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 288,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read samples the pre-write contents, so a same-address write shows up a cycle later.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wmem_burst.sv
// Binary-weight memory with init sweep, loader writes and burst reads over a valid/ready stream.
// Optional word parity is enabled by defining WMEM_PARITY_EN.
module wmem_burst
    import wmem_pkg::*;
#(
    parameter int unsigned       WORD_W   = 16,
    parameter int unsigned       DEPTH    = 288,
    parameter int unsigned       ADDR_W   = $clog2(DEPTH),
    parameter int unsigned       LEN_W    = ADDR_W + 1,
    parameter logic [WORD_W-1:0] INIT_PAT = WORD_W'(init_pat(WORD_W))
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_init_done,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [LEN_W-1:0]  i_req_len,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [WORD_W-1:0] o_rd_data,
    output logic              o_rd_last,
    output logic              o_rd_perr,
    output logic              o_err_oob
);

`ifdef WMEM_PARITY_EN
    localparam int unsigned MEM_W = WORD_W + 1;
`else
    localparam int unsigned MEM_W = WORD_W;
`endif

    wmem_state_e       r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_init_done;
    logic              r_req_ready;
    logic              r_err_oob;
    logic              r_pend;
    logic              r_pend_last;

    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_out_perr;
    logic              r_skid_valid;
    logic [WORD_W-1:0] r_skid_data;
    logic              r_skid_last;
    logic              r_skid_perr;

    logic              w_accept;
    logic              w_req_bad;
    logic [LEN_W:0]    w_sum;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_issue_last;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [WORD_W-1:0] w_wr_word;
    logic [MEM_W-1:0]  w_mem_wdata;
    logic [MEM_W-1:0]  w_mem_rdata;
    logic [WORD_W-1:0] w_push_data;
    logic              w_push_perr;

    always_comb begin
        w_accept  = i_req_valid & r_req_ready;
        w_sum     = (LEN_W+1)'(i_req_addr) + (LEN_W+1)'(i_req_len);
        w_req_bad = (i_req_len == '0) || (w_sum > (LEN_W+1)'(DEPTH));
        w_pop     = r_out_valid & i_rd_ready;
        // Words already committed to the buffer after this edge, including the in-flight read.
        w_occ     = 3'(r_out_valid) + 3'(r_skid_valid) + 3'(r_pend) - 3'(w_pop);
        // The first word is issued in the accept cycle to reach rd_valid two cycles later.
        w_issue   = ((r_state == StIdle) && w_accept && !w_req_bad)
                  || ((r_state == StBurst) && (w_occ < 3'd2));
        w_rd_addr    = (r_state == StIdle) ? i_req_addr : r_ptr;
        w_issue_last = (r_state == StIdle) ? (i_req_len == LEN_W'(1)) : (r_rem == LEN_W'(1));

        w_we      = (r_state == StInit)
                  || (i_wr_en && ({1'b0, i_wr_addr} < (ADDR_W+1)'(DEPTH)));
        w_waddr   = (r_state == StInit) ? r_cnt : i_wr_addr;
        w_wr_word = (r_state == StInit) ? INIT_PAT : i_wr_data;
    end

`ifdef WMEM_PARITY_EN
    assign w_mem_wdata = {parity64(64'(w_wr_word)), w_wr_word};
    assign w_push_perr = parity64(64'(w_mem_rdata));
`else
    assign w_mem_wdata = w_wr_word;
    assign w_push_perr = 1'b0;
`endif
    assign w_push_data = w_mem_rdata[WORD_W-1:0];

    wmem_array #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_issue),
        .i_raddr (w_rd_addr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StInit;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_init_done <= 1'b0;
            r_req_ready <= 1'b0;
            r_err_oob   <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_err_oob   <= 1'b0;
            r_pend      <= w_issue;
            if (w_issue) r_pend_last <= w_issue_last;
            if (r_state != StInit) r_init_done <= 1'b1;
            unique case (r_state)
                StInit: begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state     <= StIdle;
                        r_req_ready <= 1'b1;
                    end
                end
                StIdle: begin
                    if (w_accept) begin
                        if (w_req_bad) begin
                            r_err_oob <= 1'b1;
                        end else begin
                            r_ptr       <= i_req_addr + ADDR_W'(1);
                            r_rem       <= i_req_len - LEN_W'(1);
                            r_req_ready <= 1'b0;
                            r_state     <= (i_req_len == LEN_W'(1)) ? StDrain : StBurst;
                        end
                    end
                end
                StBurst: begin
                    if (w_issue) begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                        r_rem <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (!r_out_valid && !r_skid_valid && !r_pend) begin
                        r_state     <= StIdle;
                        r_req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Two-entry output buffer; the issue credit guarantees the skid never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_perr   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_perr  <= 1'b0;
        end else if (r_out_valid && !w_pop) begin
            if (r_pend) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_push_data;
                r_skid_last  <= r_pend_last;
                r_skid_perr  <= w_push_perr;
            end
        end else if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_out_last   <= r_skid_last;
            r_out_perr   <= r_skid_perr;
            r_skid_valid <= r_pend;
            if (r_pend) begin
                r_skid_data <= w_push_data;
                r_skid_last <= r_pend_last;
                r_skid_perr <= w_push_perr;
            end
        end else begin
            r_out_valid <= r_pend;
            if (r_pend) begin
                r_out_data <= w_push_data;
                r_out_last <= r_pend_last;
                r_out_perr <= w_push_perr;
            end
        end
    end

    assign o_init_done = r_init_done;
    assign o_req_ready = r_req_ready;
    assign o_err_oob   = r_err_oob;
    assign o_rd_valid  = r_out_valid;
    assign o_rd_data   = r_out_data;
    assign o_rd_last   = r_out_last;
    assign o_rd_perr   = r_out_perr;

endmodule

// File: tb/tb_wmem_burst.sv
// Randomised self-checking bench for wmem_burst against an address-level memory model.
`timescale 1ns/1ps
module tb_wmem_burst;

    localparam int WORD_W = 16;
    localparam int DEPTH  = 288;
    localparam int ADDR_W = 9;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              o_init_done;
    logic              i_wr_en = 1'b0;
    logic [ADDR_W-1:0] i_wr_addr = '0;
    logic [WORD_W-1:0] i_wr_data = '0;
    logic              i_req_valid = 1'b0;
    logic              o_req_ready;
    logic [ADDR_W-1:0] i_req_addr = '0;
    logic [LEN_W-1:0]  i_req_len = '0;
    logic              o_rd_valid;
    logic              i_rd_ready = 1'b1;
    logic [WORD_W-1:0] o_rd_data;
    logic              o_rd_last;
    logic              o_rd_perr;
    logic              o_err_oob;

    wmem_burst u_dut (
        .clk         (clk),
        .rst         (rst),
        .o_init_done (o_init_done),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_req_len   (i_req_len),
        .o_rd_valid  (o_rd_valid),
        .i_rd_ready  (i_rd_ready),
        .o_rd_data   (o_rd_data),
        .o_rd_last   (o_rd_last),
        .o_rd_perr   (o_rd_perr),
        .o_err_oob   (o_err_oob)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WORD_W-1:0] mem_m [DEPTH];
    bit                perr_m [DEPTH];
    int                n_tests = 0;
    int                n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset_and_init();
        int k;
        rst = 1'b1;
        i_req_valid = 1'b0;
        i_wr_en = 1'b0;
        i_rd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_init_done", 32'(o_init_done), 32'(0));
        check("rst_rd_valid", 32'(o_rd_valid), 32'(0));
        check("rst_req_ready", 32'(o_req_ready), 32'(0));
        check("rst_outputs", 32'({o_rd_data, o_rd_last, o_rd_perr, o_err_oob}), 32'(0));
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = 16'h5555;
            perr_m[a] = 1'b0;
        end
        rst = 1'b0;
        k = 0;
        while (k < 1000) begin
            @(negedge clk);
            k++;
            if (o_init_done) break;
        end
        check("init_latency", 32'(k), 32'(DEPTH + 1));
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!o_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = o_req_ready;
        if (!ok) check("req_ready_timeout", 32'(o_req_ready), 32'(1));
    endtask

    task automatic write_word(input int addr, input logic [WORD_W-1:0] data);
        i_wr_en = 1'b1;
        i_wr_addr = ADDR_W'(addr);
        i_wr_data = data;
        if (addr < DEPTH) begin
            mem_m[addr] = data;
            perr_m[addr] = 1'b0;
        end
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    // Runs one burst; abort_at >= 0 returns while word abort_at is pending.
    task automatic run_burst(input int addr, input int len, input bit rnd_ready,
                             input bit rnd_wr, input int abort_at);
        logic [WORD_W-1:0] exp_d [$];
        bit                exp_p [$];
        int                c0, first_c, last_c, idx, budget, wa;
        bit                ok, prev_stall;
        logic [WORD_W-1:0] prev_data;
        logic              prev_last, prev_perr;
        for (int i = 0; i < len; i++) begin
            exp_d.push_back(mem_m[addr + i]);
            exp_p.push_back(perr_m[addr + i]);
        end
        wait_ready(ok);
        if (!ok) return;
        i_req_valid = 1'b1;
        i_req_addr = ADDR_W'(addr);
        i_req_len = LEN_W'(len);
        c0 = cyc;
        @(negedge clk);
        i_req_valid = 1'b0;
        check("good_req_no_oob", 32'(o_err_oob), 32'(0));
        first_c = -1;
        last_c = -1;
        idx = 0;
        budget = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        prev_perr = 1'b0;
        while (idx < len && budget < 4 * len + 20) begin
            if (abort_at >= 0 && idx == abort_at && o_rd_valid) return;
            if (o_rd_valid && first_c < 0) first_c = cyc;
            if (prev_stall) begin
                check("stall_valid", 32'(o_rd_valid), 32'(1));
                check("stall_data", 32'(o_rd_data), 32'(prev_data));
                check("stall_last_perr", 32'({o_rd_last, o_rd_perr}), 32'({prev_last, prev_perr}));
            end
            i_rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            i_wr_en = 1'b0;
            if (rnd_wr && $urandom_range(0, 1) == 1) begin
                wa = int'($urandom_range(0, 511));
                if (!(wa >= addr && wa < addr + len)) write_word_now(wa);
            end
            if (o_rd_valid && i_rd_ready) begin
                check("rd_data", 32'(o_rd_data), 32'(exp_d[idx]));
                check("rd_last", 32'(o_rd_last), 32'(idx == len - 1));
                check("rd_perr", 32'(o_rd_perr), 32'(exp_p[idx]));
                idx++;
                last_c = cyc;
            end
            prev_stall = o_rd_valid && !i_rd_ready;
            prev_data = o_rd_data;
            prev_last = o_rd_last;
            prev_perr = o_rd_perr;
            @(negedge clk);
            budget++;
        end
        i_rd_ready = 1'b1;
        i_wr_en = 1'b0;
        check("burst_count", 32'(idx), 32'(len));
        check("burst_latency", 32'(first_c - c0), 32'(2));
        if (!rnd_ready) check("burst_throughput", 32'(last_c - first_c), 32'(len - 1));
        repeat (3) begin
            @(negedge clk);
            check("no_extra_word", 32'(o_rd_valid), 32'(0));
        end
    endtask

    // Drives a write for the coming edge without consuming a cycle.
    task automatic write_word_now(input int wa);
        i_wr_en = 1'b1;
        i_wr_addr = ADDR_W'(wa);
        i_wr_data = 16'($urandom);
        if (wa < DEPTH) begin
            mem_m[wa] = i_wr_data;
            perr_m[wa] = 1'b0;
        end
    endtask

    task automatic req_err(input int addr, input int len);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        i_req_valid = 1'b1;
        i_req_addr = ADDR_W'(addr);
        i_req_len = LEN_W'(len);
        @(negedge clk);
        i_req_valid = 1'b0;
        check("oob_pulse", 32'(o_err_oob), 32'(1));
        check("oob_no_valid", 32'(o_rd_valid), 32'(0));
        @(negedge clk);
        check("oob_pulse_end", 32'(o_err_oob), 32'(0));
        check("oob_back_idle", 32'(o_req_ready), 32'(1));
        check("oob_no_valid2", 32'(o_rd_valid), 32'(0));
    endtask

    initial begin
        int a, l;
        do_reset_and_init();

        run_burst(0, DEPTH, 1'b0, 1'b0, -1);

        write_word(5, 16'hA5F0);
        write_word(6, 16'h0F0F);
        write_word(300, 16'hDEAD);
        run_burst(4, 3, 1'b0, 1'b0, -1);

        repeat (3) begin
            a = int'($urandom_range(0, DEPTH - 8));
            run_burst(a, 8, 1'b1, 1'b1, -1);
        end

        req_err(280, 9);
        req_err(0, 0);
        req_err(DEPTH - 1, 2);
        run_burst(280, 8, 1'b1, 1'b0, -1);
        run_burst(DEPTH - 1, 1, 1'b0, 1'b0, -1);
        run_burst(0, 1, 1'b1, 1'b0, -1);

        repeat (8) begin
            l = int'($urandom_range(1, 40));
            a = int'($urandom_range(0, DEPTH - l));
            run_burst(a, l, 1'b1, 1'b1, -1);
        end

        write_word(103, 16'h1234);
        run_burst(100, 10, 1'b0, 1'b0, 3);
        rst = 1'b1;
        #1;
        check("midrst_rd_valid", 32'(o_rd_valid), 32'(0));
        check("midrst_init_done", 32'(o_init_done), 32'(0));
        do_reset_and_init();
        run_burst(100, 10, 1'b0, 1'b0, -1);

`ifdef WMEM_PARITY_EN
        write_word(7, 16'hC3A1);
        u_dut.u_array.r_mem[7][WORD_W] = ~u_dut.u_array.r_mem[7][WORD_W];
        perr_m[7] = 1'b1;
        run_burst(5, 4, 1'b0, 1'b0, -1);
`else
        write_word(7, 16'hC3A1);
        run_burst(5, 4, 1'b1, 1'b0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
